// File: rtl/inc_dec_pkg.sv
// Shared types and constants for the increment/decrement counter.
// State encoding, direction and arithmetic mode selects.
package inc_dec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_DEC   = 1'b0;
  localparam logic DIR_INC   = 1'b1;

endpackage

// File: rtl/inc_dec_alu.sv
// Combinational step unit: cnt +/- step with wrap or saturate.
// Flags report a carry/borrow that was wrapped or clamped.
module inc_dec_alu
  import inc_dec_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] step,
  input  logic             sel,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] next,
  output logic             wrap,
  output logic             sat
);

  logic [WIDTH:0] res;

  always_comb begin
    res  = (sel == DIR_INC)
         ? {1'b0, cnt} + {1'b0, step}
         : {1'b0, cnt} - {1'b0, step};
    next = res[WIDTH-1:0];
    wrap = 1'b0;
    sat  = 1'b0;
    // Bit WIDTH is the carry on increment and the borrow on decrement
    if (res[WIDTH]) begin
      if (sat_mode == MODE_SAT) begin
        sat  = 1'b1;
        next = (sel == DIR_INC) ? '1 : '0;
      end else begin
        wrap = 1'b1;
      end
    end
  end

endmodule

// File: rtl/inc_dec_counter.sv
// Up/down counter with free-run stepping and fixed-length bursts.
// Load overrides everything; a load during a burst aborts it silently.
module inc_dec_counter
  import inc_dec_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sel,
  input  logic [WIDTH-1:0] step,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap,
  output logic             sat,
  output logic             at_max,
  output logic             at_min,
  output logic             busy,
  output logic             done
);

  state_t             state;
  logic [LEN_W-1:0]   rem;
  logic               l_sel;
  logic               l_mode;
  logic [WIDTH-1:0]   l_step;

  logic               a_sel;
  logic               a_mode;
  logic [WIDTH-1:0]   a_step;
  logic [WIDTH-1:0]   a_next;
  logic               a_wrap;
  logic               a_sat;

  // Bursts use the latched controls, free-run uses the live ones
  assign a_sel  = (state == RUN) ? l_sel  : sel;
  assign a_mode = (state == RUN) ? l_mode : sat_mode;
  assign a_step = (state == RUN) ? l_step : step;

  inc_dec_alu #(.WIDTH(WIDTH)) u_alu (
    .cnt      (cnt),
    .step     (a_step),
    .sel      (a_sel),
    .sat_mode (a_mode),
    .next     (a_next),
    .wrap     (a_wrap),
    .sat      (a_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      wrap   <= 1'b0;
      sat    <= 1'b0;
      rem    <= '0;
      l_sel  <= 1'b0;
      l_mode <= 1'b0;
      l_step <= '0;
    end else begin
      wrap <= 1'b0;
      sat  <= 1'b0;
      if (load) begin
        cnt   <= load_val;
        rem   <= '0;
        state <= IDLE;
      end else begin
        unique case (state)
          RUN: begin
            cnt  <= a_next;
            wrap <= a_wrap;
            sat  <= a_sat;
            rem  <= rem - LEN_W'(1);
            if (rem == LEN_W'(1))
              state <= DONE;
          end
          DONE: state <= IDLE;
          IDLE: begin
            if (start && burst_len != '0) begin
              l_sel  <= sel;
              l_mode <= sat_mode;
              l_step <= step;
              rem    <= burst_len;
              state  <= RUN;
            end else if (en) begin
              cnt  <= a_next;
              wrap <= a_wrap;
              sat  <= a_sat;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign at_max = &cnt;
  assign at_min = ~|cnt;
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

endmodule

// File: tb/tb_inc_dec_counter.sv
// Directed scenarios plus randomized traffic against an
// arithmetic reference model of the counter.
module tb_inc_dec_counter;

  localparam int W   = 8;
  localparam int LW  = 8;
  localparam int MAX = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          sel;
  logic [W-1:0]  step;
  logic          sat_mode;
  logic          load;
  logic [W-1:0]  load_val;
  logic          start;
  logic [LW-1:0] burst_len;
  logic [W-1:0]  cnt;
  logic          wrap;
  logic          sat;
  logic          at_max;
  logic          at_min;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;

  inc_dec_counter #(.WIDTH(W), .LEN_W(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sel       (sel),
    .step      (step),
    .sat_mode  (sat_mode),
    .load      (load),
    .load_val  (load_val),
    .start     (start),
    .burst_len (burst_len),
    .cnt       (cnt),
    .wrap      (wrap),
    .sat       (sat),
    .at_max    (at_max),
    .at_min    (at_min),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst_n     = 1'b1;
    en        = 1'b0;
    sel       = 1'b0;
    step      = '0;
    sat_mode  = 1'b0;
    load      = 1'b0;
    load_val  = '0;
    start     = 1'b0;
    burst_len = '0;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1;
    load_val = v;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tests++;
    if ({cnt, wrap, sat, busy, done, at_min} !== {8'h00, 5'b00001}) begin
      fails++;
      $display("FAIL reset: cnt=%h w=%b s=%b b=%b d=%b amin=%b want 00/0/0/0/0/1",
               cnt, wrap, sat, busy, done, at_min);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_wrap_inc();
    logic [W-1:0] exp_c [3];
    logic         exp_w [3];
    exp_c = '{8'hFF, 8'h00, 8'h01};
    exp_w = '{1'b0, 1'b1, 1'b0};
    do_load(8'hFE);
    en = 1'b1; sel = 1'b1; step = 8'd1; sat_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (cnt !== exp_c[i] || wrap !== exp_w[i] || sat !== 1'b0) begin
        fails++;
        $display("FAIL wrap_inc[%0d]: cnt=%h wrap=%b sat=%b want %h/%b/0",
                 i, cnt, wrap, sat, exp_c[i], exp_w[i]);
      end
    end
    tests++;
    if (at_max !== 1'b0) begin
      fails++;
      $display("FAIL wrap_inc at_max: got %b want 0", at_max);
    end
    en = 1'b0;
  endtask

  task automatic test_sat_dec();
    logic [W-1:0] exp_c [3];
    logic         exp_s [3];
    exp_c = '{8'h01, 8'h00, 8'h00};
    exp_s = '{1'b0, 1'b1, 1'b1};
    do_load(8'h05);
    en = 1'b1; sel = 1'b0; step = 8'd4; sat_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (cnt !== exp_c[i] || sat !== exp_s[i] || wrap !== 1'b0) begin
        fails++;
        $display("FAIL sat_dec[%0d]: cnt=%h sat=%b wrap=%b want %h/%b/0",
                 i, cnt, sat, wrap, exp_c[i], exp_s[i]);
      end
    end
    tests++;
    if (at_min !== 1'b1) begin
      fails++;
      $display("FAIL sat_dec at_min: got %b want 1", at_min);
    end
    en = 1'b0;
    tick();
    tests++;
    if (sat !== 1'b0 || cnt !== 8'h00) begin
      fails++;
      $display("FAIL sat_hold: sat=%b cnt=%h want 0/00", sat, cnt);
    end
  endtask

  task automatic test_burst();
    int dones = 0;
    int busys = 0;
    logic [W-1:0] exp_c [3];
    exp_c = '{8'h12, 8'h14, 8'h16};
    do_load(8'h10);
    start = 1'b1; burst_len = 8'd3; sel = 1'b1; step = 8'd2; sat_mode = 1'b0;
    tick();
    start = 1'b0; sel = 1'b0; step = 8'd7;
    if (busy) busys++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (busy) busys++;
      if (done) dones++;
      tests++;
      if (cnt !== exp_c[i]) begin
        fails++;
        $display("FAIL burst_cnt[%0d]: got %h want %h", i, cnt, exp_c[i]);
      end
    end
    tick();
    if (done) dones++;
    tests++;
    if (busys != 3 || dones != 1 || done !== 1'b0) begin
      fails++;
      $display("FAIL burst_flags: busy_cycles=%0d done_pulses=%0d want 3/1",
               busys, dones);
    end
  endtask

  task automatic test_abort();
    int dones = 0;
    do_load(8'h00);
    start = 1'b1; burst_len = 8'd4; sel = 1'b1; step = 8'd1;
    tick();
    start = 1'b0;
    tick();
    load = 1'b1; load_val = 8'hAA;
    tick();
    load = 1'b0;
    tests++;
    if (cnt !== 8'hAA || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort: cnt=%h busy=%b want AA/0", cnt, busy);
    end
    for (int i = 0; i < 5; i++) begin
      if (done) dones++;
      tick();
    end
    tests++;
    if (dones != 0 || cnt !== 8'hAA) begin
      fails++;
      $display("FAIL abort_done: pulses=%0d cnt=%h want 0/AA", dones, cnt);
    end
  endtask

  task automatic test_ignored_start();
    do_load(8'h21);
    start = 1'b1; burst_len = 8'd0; sel = 1'b1; step = 8'd3;
    tick();
    tick();
    start = 1'b0;
    tests++;
    if (busy !== 1'b0 || cnt !== 8'h21) begin
      fails++;
      $display("FAIL zero_len: busy=%b cnt=%h want 0/21", busy, cnt);
    end
    start = 1'b1; burst_len = 8'd3; load = 1'b1; load_val = 8'h33;
    tick();
    start = 1'b0; load = 1'b0;
    tests++;
    if (busy !== 1'b0 || cnt !== 8'h33) begin
      fails++;
      $display("FAIL start_load: busy=%b cnt=%h want 0/33", busy, cnt);
    end
    tick();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || cnt !== 8'h33) begin
      fails++;
      $display("FAIL start_load2: busy=%b done=%b cnt=%h want 0/0/33",
               busy, done, cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_load(8'hFF);
    start = 1'b1; burst_len = 8'd5; sel = 1'b1; step = 8'd1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests++;
    if ({cnt, wrap, sat, busy, done} !== 12'h000) begin
      fails++;
      $display("FAIL reset_mid: cnt=%h w=%b s=%b b=%b d=%b want all 0",
               cnt, wrap, sat, busy, done);
    end
    tick();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || cnt !== 8'h00) begin
      fails++;
      $display("FAIL reset_mid2: done=%b busy=%b cnt=%h want 0/0/00",
               done, busy, cnt);
    end
  endtask

  // Reference step: plain integer arithmetic on the count value
  function automatic void model_step(
    input  int c, input int s, input bit inc, input bit satm,
    output int n, output bit w, output bit sa);
    int v;
    v  = inc ? c + s : c - s;
    w  = 1'b0;
    sa = 1'b0;
    n  = v;
    if (v > MAX || v < 0) begin
      if (satm) begin
        sa = 1'b1;
        n  = (v > MAX) ? MAX : 0;
      end else begin
        w = 1'b1;
        n = (v + (MAX + 1)) % (MAX + 1);
      end
    end
  endfunction

  task automatic test_random();
    int  m_cnt  = 0;
    bit  m_wrap = 0;
    bit  m_sat  = 0;
    int  m_left = 0;
    bit  m_done = 0;
    bit  b_inc  = 0;
    bit  b_sat  = 0;
    int  b_step = 0;
    int  n;
    bit  w;
    bit  sa;
    rst_n = 1'b0;
    tick();
    for (int it = 0; it < 600; it++) begin
      rst_n     = ($urandom_range(0, 39) != 0);
      load      = ($urandom_range(0, 11) == 0);
      load_val  = W'($urandom);
      start     = ($urandom_range(0, 5) == 0);
      burst_len = LW'($urandom_range(0, 5));
      en        = ($urandom_range(0, 2) != 0);
      sel       = W'($urandom) > 8'd100;
      sat_mode  = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0:       step = '0;
        1:       step = W'($urandom_range(1, 3));
        default: step = W'($urandom);
      endcase
      m_wrap = 0;
      m_sat  = 0;
      if (!rst_n) begin
        m_cnt = 0; m_left = 0; m_done = 0;
        b_inc = 0; b_sat = 0; b_step = 0;
      end else if (load) begin
        m_cnt = load_val; m_left = 0; m_done = 0;
      end else if (m_left > 0) begin
        model_step(m_cnt, b_step, b_inc, b_sat, n, w, sa);
        m_cnt = n; m_wrap = w; m_sat = sa;
        m_left--;
        m_done = (m_left == 0);
      end else if (m_done) begin
        m_done = 0;
      end else if (start && burst_len != 0) begin
        b_inc = sel; b_sat = sat_mode; b_step = step;
        m_left = burst_len;
      end else if (en) begin
        model_step(m_cnt, step, sel, sat_mode, n, w, sa);
        m_cnt = n; m_wrap = w; m_sat = sa;
      end
      tick();
      tests++;
      if (cnt !== W'(m_cnt) || wrap !== m_wrap || sat !== m_sat ||
          busy !== (m_left > 0) || done !== m_done ||
          at_max !== (m_cnt == MAX) || at_min !== (m_cnt == 0)) begin
        fails++;
        $display("FAIL random[%0d]: cnt=%h w=%b s=%b b=%b d=%b mx=%b mn=%b want %h/%b/%b/%b/%b",
                 it, cnt, wrap, sat, busy, done, at_max, at_min,
                 W'(m_cnt), m_wrap, m_sat, (m_left > 0), m_done);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_wrap_inc();
    test_sat_dec();
    test_burst();
    test_abort();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
